// File: rtl/dm_pkg.sv
// Shared load-type codes, FSM encoding and RAM latency bounds for dm_reader.
package dm_pkg;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } ld_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = 3;

  // Request fields held from accept until the response is built.
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  typ;
    logic [1:0]  lo;
    logic        bad;
  } ld_req_t;

  function automatic logic type_legal(input logic [2:0] t);
    return t <= LD_LBU;
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      LD_LW:         return a != 2'b00;
      LD_LH, LD_LHU: return a[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Lane select and sign/zero extension of a RAM word for one load.
module load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  typ,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = '0;
    h      = '0;
    result = '0;
    case (addr)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (typ)
      LD_LW:   result = word;
      LD_LH:   result = {{16{h[15]}}, h};
      LD_LHU:  result = {16'h0, h};
      LD_LB:   result = {{24{b[7]}}, b};
      LD_LBU:  result = {24'h0, b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_reader.sv
// Single-outstanding data-memory load unit: issue, wait MEM_LAT, extend, respond.
// Define DM_READER_ALIGN_CHECK_EN to reject misaligned lw/lh/lhu without a RAM read.
module dm_reader
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_pc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [31:0]       resp_pc,
  output logic              resp_err
);

  localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  state_e           state;
  ld_req_t          cap;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      ext;
  logic             acc_bad;

  if (ADDR_W < 30) begin : g_hi
    logic unused_hi;
    assign unused_hi = &{1'b0, req_addr[31:ADDR_W+2]};
  end

  always_comb begin
    acc_bad = !type_legal(req_type);
`ifdef DM_READER_ALIGN_CHECK_EN
    acc_bad = acc_bad || misaligned(req_type, req_addr[1:0]);
`endif
  end

  // Gated by reset so the port reads 0 while held and 1 as soon as released.
  assign req_ready = reset && (state == S_IDLE);

  load_ext u_ext (
    .word   (mem_rdata),
    .addr   (cap.lo),
    .typ    (cap.typ),
    .result (ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cap        <= '0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      resp_pc    <= '0;
    end else begin
      mem_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap      <= '{pc: req_pc, typ: req_type, lo: req_addr[1:0], bad: acc_bad};
            mem_addr <= req_addr[ADDR_W+1:2];
            mem_en   <= !acc_bad;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cap.bad) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
            resp_pc    <= cap.pc;
            state      <= S_RESP;
          end else begin
            cnt   <= CNT_W'(1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The ISSUE cycle is count zero; rdata is live on the last WAIT cycle.
          if (cnt == LAT_C) begin
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= ext;
            resp_pc    <= cap.pc;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_reader.sv
// Directed bench for dm_reader: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_dm_reader;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_type = '0;
  logic [31:0] req_pc = '0;
  logic        resp_ready = 1'b0;

  logic        rv1, rdy1, en1, vld1, err1;
  logic [9:0]  maddr1;
  logic [31:0] rdata1, data1, pc1;
  logic        rv3, rdy3, en3, vld3, err3;
  logic [9:0]  maddr3;
  logic [31:0] rdata3, data3, pc3;

  assign rv1 = req_valid & ~sel;
  assign rv3 = req_valid & sel;

  dm_reader #(.ADDR_W(10), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_addr(req_addr),
    .req_type(req_type), .req_pc(req_pc), .mem_en(en1), .mem_addr(maddr1),
    .mem_rdata(rdata1), .resp_valid(vld1), .resp_ready(resp_ready), .resp_data(data1),
    .resp_pc(pc1), .resp_err(err1));

  dm_reader #(.ADDR_W(10), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rdy3), .req_addr(req_addr),
    .req_type(req_type), .req_pc(req_pc), .mem_en(en3), .mem_addr(maddr3),
    .mem_rdata(rdata3), .resp_valid(vld3), .resp_ready(resp_ready), .resp_data(data3),
    .resp_pc(pc3), .resp_err(err3));

  wire        rdy_s   = sel ? rdy3   : rdy1;
  wire        en_s    = sel ? en3    : en1;
  wire        vld_s   = sel ? vld3   : vld1;
  wire        err_s   = sel ? err3   : err1;
  wire [9:0]  maddr_s = sel ? maddr3 : maddr1;
  wire [31:0] data_s  = sel ? data3  : data1;
  wire [31:0] pc_s    = sel ? pc3    : pc1;

  // RAM models: data valid exactly MEM_LAT cycles after the mem_en cycle, junk otherwise.
  logic [31:0] mem [0:1023];
  logic [1:0]  v3 = '0;
  logic [9:0]  a3_0 = '0, a3_1 = '0;
  always @(posedge clk) begin
    rdata1 <= en1 ? mem[maddr1] : 32'hDEAD_BEEF;
    v3     <= {v3[0], en3};
    a3_0   <= maddr3;
    a3_1   <= a3_0;
    rdata3 <= v3[1] ? mem[a3_1] : 32'hDEAD_BEEF;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] o_data, o_pc;
  logic        o_err, o_stable, o_rdy;
  logic [9:0]  o_maddr;
  int          o_lat, o_en;

  task automatic load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] pc,
                      input int stall);
    int n;
    n = 0;
    while (!rdy_s && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_addr = a; req_type = t; req_pc = pc;
    @(negedge clk);
    req_valid = 1'b0;
    o_maddr = maddr_s;
    o_lat = 1;
    o_en = int'(en_s);
    while (!vld_s && o_lat < 50) begin @(negedge clk); o_lat++; o_en += int'(en_s); end
    o_data = data_s; o_err = err_s; o_pc = pc_s; o_stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!vld_s || data_s !== o_data || rdy_s || en_s) o_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    o_rdy = rdy_s;
  endtask

  logic [31:0] exp_d;
  logic        exp_e;
  int          exp_en;
  bit          saw_vld;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[5] = 32'h8081_7F02;
    mem[1] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy_s), 0);
    chk("rst_mem_en", 32'(en_s), 0);
    chk("rst_valid", 32'(vld_s), 0);
    chk("rst_err", 32'(err_s), 0);
    chk("rst_data", data_s, 0);
    chk("rst_maddr", 32'(maddr_s), 0);
    reset = 1'b1;
    #1 chk("ready_after_rst", 32'(rdy_s), 1);

    load(32'h17, LD_LB, 32'h100, 0);
    chk("lb_data", o_data, 32'hFFFF_FF80);
    chk("lb_err", 32'(o_err), 0);
    chk("lb_lat", 32'(o_lat), 3);
    chk("lb_mem_en", 32'(o_en), 1);
    chk("lb_maddr", 32'(o_maddr), 5);
    chk("lb_pc", o_pc, 32'h100);
    chk("lb_ready", 32'(o_rdy), 1);

    load(32'h16, LD_LBU, 32'h104, 0); chk("lbu16", o_data, 32'h0000_0081);
    load(32'h16, LD_LHU, 32'h108, 0); chk("lhu16", o_data, 32'h0000_8081);
    load(32'h14, LD_LH, 32'h10C, 0);  chk("lh14", o_data, 32'h0000_7F02);
    load(32'h16, LD_LH, 32'h110, 0);  chk("lh16", o_data, 32'hFFFF_8081);
    load(32'h14, LD_LBU, 32'h114, 0); chk("lbu14", o_data, 32'h0000_0002);
    load(32'h15, LD_LB, 32'h118, 0);  chk("lb15", o_data, 32'h0000_007F);

    load(32'h14, LD_LW, 32'h200, 5);
    chk("stall_stable", 32'(o_stable), 1);
    chk("stall_data", o_data, 32'h8081_7F02);
    chk("stall_ready", 32'(o_rdy), 1);

    load(32'h14, 3'b111, 32'h204, 0);
    chk("ill_err", 32'(o_err), 1);
    chk("ill_data", o_data, 0);
    chk("ill_mem_en", 32'(o_en), 0);
    chk("ill_lat", 32'(o_lat), 2);
    chk("ill_pc", o_pc, 32'h204);

`ifdef DM_READER_ALIGN_CHECK_EN
    exp_d = 32'h0; exp_e = 1'b1; exp_en = 0;
`else
    exp_d = 32'h1234_5678; exp_e = 1'b0; exp_en = 1;
`endif
    load(32'h06, LD_LW, 32'h300, 0);
    chk("mis_lw_data", o_data, exp_d);
    chk("mis_lw_err", 32'(o_err), 32'(exp_e));
    chk("mis_lw_mem_en", 32'(o_en), 32'(exp_en));
`ifdef DM_READER_ALIGN_CHECK_EN
    exp_d = 32'h0;
`else
    exp_d = 32'h0000_7F02;
`endif
    load(32'h15, LD_LHU, 32'h304, 0);
    chk("mis_lhu_data", o_data, exp_d);
    chk("mis_lhu_err", 32'(o_err), 32'(exp_e));

    sel = 1'b1;
    load(32'h04, LD_LW, 32'h400, 0);
    chk("l3_data", o_data, 32'h1234_5678);
    chk("l3_lat", 32'(o_lat), 5);

    // Reset in WAIT: in-flight load must vanish and late RAM data be ignored.
    req_valid = 1'b1; req_addr = 32'h14; req_type = LD_LW; req_pc = 32'h500;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", 32'(rdy_s), 0);
    chk("arst_mem_en", 32'(en_s), 0);
    chk("arst_valid", 32'(vld_s), 0);
    chk("arst_err", 32'(err_s), 0);
    chk("arst_data", data_s, 0);
    chk("arst_pc", pc_s, 0);
    chk("arst_maddr", 32'(maddr_s), 0);
    @(negedge clk); reset = 1'b1;
    saw_vld = 1'b0;
    repeat (10) begin @(negedge clk); if (vld_s) saw_vld = 1'b1; end
    chk("arst_no_resp", 32'(saw_vld), 0);
    load(32'h14, LD_LW, 32'h600, 0);
    chk("post_rst_data", o_data, 32'h8081_7F02);
    chk("post_rst_err", 32'(o_err), 0);
    chk("post_rst_pc", o_pc, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
